// File: rtl/uart_rsp_packetizer_pkg.sv
// Shared constants, state encoding and LEN helper for the response packetizer.
// The CRC-8 polynomial here is used when UART_RSP_CRC8_EN is defined.
package uart_rsp_packetizer_pkg;

    localparam logic [7:0] SOF_DEFAULT = 8'hA5;
    localparam logic [7:0] CRC8_POLY   = 8'h07;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_WAIT_IDLE = 3'd2,
        ST_START     = 3'd3,
        ST_WAIT_BUSY = 3'd4,
        ST_WAIT_DONE = 3'd5,
        ST_DONE      = 3'd6
    } pkt_state_t;

    // LEN field carries the number of payload bytes in the frame.
    function automatic logic [7:0] len_byte(input int payload_bytes);
        return 8'(payload_bytes);
    endfunction

endpackage

// File: rtl/uart_rsp_packetizer_chk_accum.sv
// One-byte checksum step: XOR by default, CRC-8/0x07 (MSB first, no reflection)
// when UART_RSP_CRC8_EN is defined. Shared with the receive-side checker.
module rsp_chk_accum
    import uart_rsp_packetizer_pkg::*;
(
    input  logic [7:0] i_byte,
    input  logic [7:0] i_chk,
    output logic [7:0] o_chk
);

`ifdef UART_RSP_CRC8_EN
    logic [7:0] w_crc;

    always_comb begin
        w_crc = i_chk ^ i_byte;
        for (int b = 0; b < 8; b++) begin
            w_crc = w_crc[7] ? ((w_crc << 1) ^ CRC8_POLY) : (w_crc << 1);
        end
    end

    assign o_chk = w_crc;
`else
    assign o_chk = i_chk ^ i_byte;
`endif

endmodule

// File: rtl/uart_rsp_packetizer.sv
// Frames one response as SOF, CMD, LEN, D[n-1]..D[0], CHK over the UART byte interface.
// Checksum flavour selected by UART_RSP_CRC8_EN (CRC-8 when defined, XOR otherwise).
module uart_rsp_packetizer
    import uart_rsp_packetizer_pkg::*;
#(
    parameter int         PAYLOAD_BYTES = 4,
    parameter logic [7:0] SOF_BYTE      = SOF_DEFAULT,
    parameter int         BUSY_WAIT     = 8
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [7:0]  i_req_cmd,
    input  logic [31:0] i_req_data,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_start,
    input  logic        i_tx_busy,
    output logic        o_pkt_busy,
    output logic        o_pkt_done,
    output logic [2:0]  o_dbg_state
);

    localparam logic [2:0] LAST_IDX = 3'(PAYLOAD_BYTES + 3);
    localparam logic [2:0] DATA_TOP = 3'(PAYLOAD_BYTES + 2);
    localparam logic [7:0] TO_LAST  = 8'(BUSY_WAIT - 1);
    localparam logic [7:0] LEN_BYTE = len_byte(PAYLOAD_BYTES);

    pkt_state_t  r_state;
    pkt_state_t  w_next;
    logic [2:0]  r_idx;
    logic [7:0]  r_chk;
    logic [7:0]  r_tx_data;
    logic [7:0]  r_to_cnt;
    logic [7:0]  r_cmd;
    logic [31:0] r_data;
    logic [1:0]  w_data_pos;
    logic [7:0]  w_data_byte;
    logic [7:0]  w_frame_byte;
    logic [7:0]  w_chk_next;
    logic        w_fold;
    logic        w_accept;

    assign w_accept = (r_state == ST_IDLE) && i_req_valid;

    rsp_chk_accum u_chk (
        .i_byte (w_frame_byte),
        .i_chk  (r_chk),
        .o_chk  (w_chk_next)
    );

    // Data bytes go out MSB first: index 3 carries D[n-1], index n+2 carries D[0].
    always_comb begin
        w_data_pos = DATA_TOP[1:0] - r_idx[1:0];
        case (w_data_pos)
            2'd0:    w_data_byte = r_data[7:0];
            2'd1:    w_data_byte = r_data[15:8];
            2'd2:    w_data_byte = r_data[23:16];
            default: w_data_byte = r_data[31:24];
        endcase
        w_fold = 1'b0;
        if (r_idx == 3'd0) begin
            w_frame_byte = SOF_BYTE;
        end else if (r_idx == 3'd1) begin
            w_frame_byte = r_cmd;
            w_fold       = 1'b1;
        end else if (r_idx == 3'd2) begin
            w_frame_byte = LEN_BYTE;
            w_fold       = 1'b1;
        end else if (r_idx == LAST_IDX) begin
            w_frame_byte = r_chk;
        end else begin
            w_frame_byte = w_data_byte;
            w_fold       = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:      if (i_req_valid) w_next = ST_LOAD;
            ST_LOAD:      w_next = ST_WAIT_IDLE;
            ST_WAIT_IDLE: if (!i_tx_busy) w_next = ST_START;
            ST_START:     w_next = ST_WAIT_BUSY;
            // A UART that never reports busy is treated as having taken the byte.
            ST_WAIT_BUSY: if (i_tx_busy || (r_to_cnt == TO_LAST)) w_next = ST_WAIT_DONE;
            ST_WAIT_DONE: if (!i_tx_busy) w_next = (r_idx == LAST_IDX) ? ST_DONE : ST_LOAD;
            ST_DONE:      w_next = ST_IDLE;
            default:      w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        o_req_ready = (r_state == ST_IDLE);
        o_tx_start  = (r_state == ST_START);
        o_pkt_busy  = (r_state != ST_IDLE) && (r_state != ST_DONE);
        o_pkt_done  = (r_state == ST_DONE);
        o_tx_data   = r_tx_data;
        o_dbg_state = r_state;
    end

    // tx_data only changes in LOAD, so it is stable whenever the UART may sample it.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_idx     <= 3'd0;
            r_chk     <= 8'd0;
            r_tx_data <= 8'd0;
            r_to_cnt  <= 8'd0;
            r_cmd     <= 8'd0;
            r_data    <= 32'd0;
        end else begin
            if (w_accept) begin
                r_cmd  <= i_req_cmd;
                r_data <= i_req_data;
                r_idx  <= 3'd0;
                r_chk  <= 8'd0;
            end
            if (r_state == ST_LOAD) begin
                r_tx_data <= w_frame_byte;
                if (w_fold) begin
                    r_chk <= w_chk_next;
                end
            end
            if (r_state == ST_START) begin
                r_to_cnt <= 8'd0;
            end else if ((r_state == ST_WAIT_BUSY) && (r_to_cnt != TO_LAST)) begin
                r_to_cnt <= r_to_cnt + 8'd1;
            end
            if ((r_state == ST_WAIT_DONE) && !i_tx_busy && (r_idx != LAST_IDX)) begin
                r_idx <= r_idx + 3'd1;
            end
        end
    end

endmodule
